// File: rtl/tug_field.sv
// tug_field: tug-of-war playfield for a row of N_LIGHTS LEDs.
// Tracks one lit position, moves it on button presses (edge-detected), detects
// round wins at either end, keeps per-player scores and stops once a player
// reaches MATCH_SCORE round wins.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   L, R       in   synchronized button levels, 1 = pressed
//   lights     out  playfield LEDs, one-hot while playing, zero otherwise
//   leftWin    out  left round/match win being displayed
//   rightWin   out  right round/match win being displayed
//   leftScore  out  left round-win count
//   rightScore out  right round-win count
//   matchOver  out  match finished, frozen until reset
module tug_field #(
  parameter int unsigned N_LIGHTS    = 9,
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned MATCH_SCORE = 3,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L,
  input  logic                R,
  output logic [N_LIGHTS-1:0] lights,
  output logic                leftWin,
  output logic                rightWin,
  output logic [SCORE_W-1:0]  leftScore,
  output logic [SCORE_W-1:0]  rightScore,
  output logic                matchOver
);

  localparam int unsigned PosW = $clog2(N_LIGHTS);
  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PosW-1:0]    PosCentre = PosW'((N_LIGHTS - 1) / 2);
  localparam logic [PosW-1:0]    PosLeft   = PosW'(N_LIGHTS - 1);
  localparam logic [CntW-1:0]    HoldLoad  = CntW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MatchVal  = SCORE_W'(MATCH_SCORE);

  typedef enum logic [1:0] {StPlay, StHold, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [PosW-1:0]    r_pos, w_pos_next;
  logic [CntW-1:0]    r_hold_cnt, w_hold_cnt_next;
  logic [SCORE_W-1:0] r_left_score, w_left_score_next;
  logic [SCORE_W-1:0] r_right_score, w_right_score_next;
  logic               r_left_win, w_left_win_next;
  logic               r_right_win, w_right_win_next;
  logic               r_prev_l, r_prev_r;

  logic               w_press_l, w_press_r, w_move_l, w_move_r;
  logic [SCORE_W-1:0] w_left_inc, w_right_inc;

  assign w_press_l   = L & ~r_prev_l;
  assign w_press_r   = R & ~r_prev_r;
  // Simultaneous presses cancel out.
  assign w_move_l    = w_press_l & ~w_press_r;
  assign w_move_r    = w_press_r & ~w_press_l;
  assign w_left_inc  = r_left_score + SCORE_W'(1);
  assign w_right_inc = r_right_score + SCORE_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StPlay;
      r_pos         <= PosCentre;
      r_hold_cnt    <= '0;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_left_win    <= 1'b0;
      r_right_win   <= 1'b0;
      // Buttons held through reset must not register as a press.
      r_prev_l      <= 1'b1;
      r_prev_r      <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_pos         <= w_pos_next;
      r_hold_cnt    <= w_hold_cnt_next;
      r_left_score  <= w_left_score_next;
      r_right_score <= w_right_score_next;
      r_left_win    <= w_left_win_next;
      r_right_win   <= w_right_win_next;
      r_prev_l      <= L;
      r_prev_r      <= R;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next       = r_state;
    w_pos_next         = r_pos;
    w_hold_cnt_next    = r_hold_cnt;
    w_left_score_next  = r_left_score;
    w_right_score_next = r_right_score;
    w_left_win_next    = r_left_win;
    w_right_win_next   = r_right_win;
    unique case (r_state)
      StPlay: begin
        if (w_move_l) begin
          if (r_pos == PosLeft) begin
            w_left_score_next = w_left_inc;
            w_left_win_next   = 1'b1;
            if (w_left_inc == MatchVal) begin
              w_state_next = StDone;
            end else begin
              w_state_next    = StHold;
              w_hold_cnt_next = HoldLoad;
            end
          end else begin
            w_pos_next = r_pos + PosW'(1);
          end
        end else if (w_move_r) begin
          if (r_pos == '0) begin
            w_right_score_next = w_right_inc;
            w_right_win_next   = 1'b1;
            if (w_right_inc == MatchVal) begin
              w_state_next = StDone;
            end else begin
              w_state_next    = StHold;
              w_hold_cnt_next = HoldLoad;
            end
          end else begin
            w_pos_next = r_pos - PosW'(1);
          end
        end
      end
      StHold: begin
        if (r_hold_cnt == '0) begin
          w_state_next     = StPlay;
          w_pos_next       = PosCentre;
          w_left_win_next  = 1'b0;
          w_right_win_next = 1'b0;
        end else begin
          w_hold_cnt_next = r_hold_cnt - CntW'(1);
        end
      end
      StDone: begin
      end
      default: begin
        w_state_next = StPlay;
        w_pos_next   = PosCentre;
      end
    endcase
  end

  // Outputs
  always_comb begin
    lights     = '0;
    if (r_state == StPlay) begin
      lights = N_LIGHTS'(1) << r_pos;
    end
    leftWin    = r_left_win;
    rightWin   = r_right_win;
    leftScore  = r_left_score;
    rightScore = r_right_score;
    matchOver  = (r_state == StDone);
  end

endmodule

// File: tb/tb_tug_field.sv
// Directed testbench for tug_field with N_LIGHTS=5, HOLD_CYCLES=4, MATCH_SCORE=2.
module tb_tug_field;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       L = 1'b0;
  logic       R = 1'b0;
  logic [4:0] lights;
  logic       leftWin, rightWin, matchOver;
  logic [2:0] leftScore, rightScore;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tug_field #(
    .N_LIGHTS   (5),
    .SCORE_W    (3),
    .MATCH_SCORE(2),
    .HOLD_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .L         (L),
    .R         (R),
    .lights    (lights),
    .leftWin   (leftWin),
    .rightWin  (rightWin),
    .leftScore (leftScore),
    .rightScore(rightScore),
    .matchOver (matchOver)
  );

  // Drive buttons, let one rising edge pass, return 1ns after it.
  task automatic cyc(input logic l, input logic r);
    L = l;
    R = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_lights, input logic e_lw,
                         input logic e_rw, input logic [2:0] e_ls, input logic [2:0] e_rs,
                         input logic e_mo);
    chk({tag, ".lights"}, 32'(lights), 32'(e_lights));
    chk({tag, ".leftWin"}, 32'(leftWin), 32'(e_lw));
    chk({tag, ".rightWin"}, 32'(rightWin), 32'(e_rw));
    chk({tag, ".leftScore"}, 32'(leftScore), 32'(e_ls));
    chk({tag, ".rightScore"}, 32'(rightScore), 32'(e_rs));
    chk({tag, ".matchOver"}, 32'(matchOver), 32'(e_mo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with L held, then release, then idle.
    reset = 1'b1;
    cyc(1, 0);
    cyc(1, 0);
    chk_all("reset", 5'b00100, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(1, 0);
    chk_all("held_through_reset", 5'b00100, 0, 0, 0, 0, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk_all("idle", 5'b00100, 0, 0, 0, 0, 0);

    // Held L produces one move only.
    cyc(1, 0);
    chk("l_first_edge", 32'(lights), 32'(5'b01000));
    for (int i = 0; i < 4; i++) cyc(1, 0);
    chk("l_held", 32'(lights), 32'(5'b01000));
    cyc(0, 0);
    cyc(0, 1);
    chk("r_pulse", 32'(lights), 32'(5'b00100));
    cyc(0, 0);

    // Simultaneous presses cancel; R rising alone while L held moves right.
    cyc(1, 1);
    chk("both_press", 32'(lights), 32'(5'b00100));
    cyc(1, 0);
    chk("l_held_r_fall", 32'(lights), 32'(5'b00100));
    cyc(1, 1);
    chk("r_alone_l_held", 32'(lights), 32'(5'b00010));
    cyc(0, 0);
    cyc(1, 0);
    chk("back_to_centre", 32'(lights), 32'(5'b00100));
    cyc(0, 0);

    // First left round win and the hold window.
    cyc(1, 0);
    chk("lw1_step1", 32'(lights), 32'(5'b01000));
    cyc(0, 0);
    cyc(1, 0);
    chk("lw1_step2", 32'(lights), 32'(5'b10000));
    cyc(0, 0);
    cyc(1, 0);
    chk_all("lw1_win", 5'b00000, 1, 0, 1, 0, 0);
    cyc(0, 0);
    chk_all("hold2", 5'b00000, 1, 0, 1, 0, 0);
    cyc(1, 0);
    chk_all("hold3_press_ignored", 5'b00000, 1, 0, 1, 0, 0);
    cyc(0, 0);
    chk_all("hold4", 5'b00000, 1, 0, 1, 0, 0);
    cyc(0, 0);
    chk_all("hold_end", 5'b00100, 0, 0, 1, 0, 0);

    // Second left round win ends the match.
    cyc(1, 0);
    chk("lw2_step1", 32'(lights), 32'(5'b01000));
    cyc(0, 0);
    cyc(1, 0);
    chk("lw2_step2", 32'(lights), 32'(5'b10000));
    cyc(0, 0);
    cyc(1, 0);
    chk_all("match_win", 5'b00000, 1, 0, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      cyc(0, 1);
      cyc(0, 0);
      cyc(1, 0);
    end
    chk_all("done_frozen", 5'b00000, 1, 0, 2, 0, 1);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    chk_all("reset_from_done", 5'b00100, 0, 0, 0, 0, 0);
    cyc(0, 0);

    // Reset during HOLD, then a right round win.
    cyc(0, 1);
    chk("rw_a_step1", 32'(lights), 32'(5'b00010));
    cyc(0, 0);
    cyc(0, 1);
    chk("rw_a_step2", 32'(lights), 32'(5'b00001));
    cyc(0, 0);
    cyc(0, 1);
    chk_all("rw_a_win", 5'b00000, 0, 1, 0, 1, 0);
    cyc(0, 0);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    chk_all("reset_in_hold", 5'b00100, 0, 0, 0, 0, 0);
    cyc(0, 0);
    chk_all("after_reset_in_hold", 5'b00100, 0, 0, 0, 0, 0);
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);
    chk("rw_b_step2", 32'(lights), 32'(5'b00001));
    cyc(0, 0);
    cyc(0, 1);
    chk_all("rw_b_win", 5'b00000, 0, 1, 0, 1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk_all("rw_b_hold4", 5'b00000, 0, 1, 0, 1, 0);
    cyc(0, 0);
    chk_all("rw_b_hold_end", 5'b00100, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
